// File: rtl/ws2812b_if.sv
// ws2812b_if: control bundle between the LED ring controller and the WS2812B
// serializer.
//   refresh    : frame request (controller -> driver)
//   led_mask   : NUM_LEDS-bit lit mask, bit i lights pixel i (controller -> driver)
//   intensity  : 8-bit channel value for lit pixels (controller -> driver)
//   busy       : frame (incl. latch) in progress (driver -> controller)
//   frame_done : one-cycle pulse when the latch period ends (driver -> controller)
`timescale 1ns/1ps
interface ws2812b_if #(
  parameter int NUM_LEDS = 12
);
  logic                refresh;
  logic [NUM_LEDS-1:0] led_mask;
  logic [7:0]          intensity;
  logic                busy;
  logic                frame_done;

  modport master (
    output refresh, led_mask, intensity,
    input  busy, frame_done
  );

  modport slave (
    input  refresh, led_mask, intensity,
    output busy, frame_done
  );
endinterface

// File: rtl/ws2812b_driver.sv
// ws2812b_driver: serializes an LED mask / intensity snapshot into the
// single-wire WS2812B protocol for a chain of NUM_LEDS pixels (GRB, MSB first,
// pixel 0 first), followed by a RES_CYCLES low latch.
// Ports:
//   clk      : system clock (40 MHz)
//   res_n    : asynchronous active-low reset
//   ctrl     : ws2812b_if slave modport (refresh, led_mask, intensity in;
//              busy, frame_done out)
//   led_data : WS2812B serial data line
`timescale 1ns/1ps
module ws2812b_driver #(
  parameter int NUM_LEDS   = 12,
  parameter int BIT_CYCLES = 50,
  parameter int T0H_CYCLES = 16,
  parameter int T1H_CYCLES = 32,
  parameter int RES_CYCLES = 12000
) (
  input  logic        clk,
  input  logic        res_n,
  ws2812b_if.slave    ctrl,
  output logic        led_data
);

  localparam int CNT_MAX = (BIT_CYCLES > RES_CYCLES) ? BIT_CYCLES : RES_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PIX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CNT_W-1:0] T0H_END = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_END = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RES_END = CNT_W'(RES_CYCLES - 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(NUM_LEDS - 1);
  localparam logic [4:0]       BIT_FIRST = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [4:0]          bit_q, bit_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [7:0]          int_q, int_d;
  logic                pend_q, pend_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [23:0]         word;
  logic                cur_bit;
  logic [CNT_W-1:0]    high_end;

  // GRB word for one pixel; all three channels carry the same level.
  function automatic logic [23:0] pixel_word(input logic lit, input logic [7:0] lvl);
    pixel_word = lit ? {lvl, lvl, lvl} : 24'h000000;
  endfunction

  assign word     = pixel_word(mask_q[pix_q], int_q);
  assign cur_bit  = word[bit_q];
  assign high_end = cur_bit ? T1H_END : T0H_END;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pix_q   <= '0;
      bit_q   <= '0;
      mask_q  <= '0;
      int_q   <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      bit_q   <= bit_d;
      mask_q  <= mask_d;
      int_q   <= int_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    bit_d   = bit_q;
    mask_d  = mask_q;
    int_d   = int_q;
    pend_d  = pend_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Requests during a frame collapse into one pending flag.
    if (state_q != S_IDLE && ctrl.refresh) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl.refresh) begin
          state_d = S_HIGH;
          mask_d  = ctrl.led_mask;
          int_d   = ctrl.intensity;
          pix_d   = '0;
          bit_d   = BIT_FIRST;
          cnt_d   = '0;
          led_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      // cnt runs across the whole bit period so LOW ends at a fixed count
      // regardless of the high time chosen for the bit.
      S_HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == high_end) begin
          state_d = S_LOW;
          led_d   = 1'b0;
        end
      end

      S_LOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            state_d = S_HIGH;
            led_d   = 1'b1;
          end else if (pix_q != PIX_LAST) begin
            pix_d   = pix_q + PIX_W'(1);
            bit_d   = BIT_FIRST;
            state_d = S_HIGH;
            led_d   = 1'b1;
          end else begin
            state_d = S_LATCH;
          end
        end
      end

      S_LATCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RES_END) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // A request landing on this very edge is treated as pending too,
          // otherwise it would be dropped on the way back to IDLE.
          if (pend_q || ctrl.refresh) begin
            pend_d  = 1'b0;
            state_d = S_HIGH;
            mask_d  = ctrl.led_mask;
            int_d   = ctrl.intensity;
            pix_d   = '0;
            bit_d   = BIT_FIRST;
            led_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign led_data        = led_q;
  assign ctrl.busy       = busy_q;
  assign ctrl.frame_done = done_q;

endmodule
